uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_if.sv | 31 +++
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// The PARITY state is only reachable when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    // Even parity: the data bits plus the parity bit must XOR to zero.
    function automatic logic even_parity_bad(input logic [UART_DATA_BITS-1:0] data,
                                             input logic                      par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-in / byte-out signal bundle of the UART receiver.
// master: the receiver itself; slave: the board pin driver and byte consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic                      rx;
    logic [UART_DATA_BITS-1:0] data_out;
    logic                      valid;
    logic                      parity_err;
    logic                      frame_err;
    logic                      busy;

    modport master (
        input  rx,
        output data_out,
        output valid,
        output parity_err,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data_out,
        input  valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous level input.
// Both flops reset to the line idle level so a reset never looks like a start edge.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the async input into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= UART_IDLE_LEVEL;
            sync_q <= UART_IDLE_LEVEL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Define UART_RX_PARITY_EN to include the parity bit (11-bit frame); otherwise the
// frame is 10 bits and parity_err is tied low.
//
// state  | meaning
// IDLE   | line idle, waiting for a 1->0 edge on the synchronized rx
// START  | counting half a bit, then confirming the start bit is still low
// DATA   | sampling 8 data bits at their centres, LSB first
// PARITY | sampling the even-parity bit (parity build only)
// STOP   | sampling the stop bit and publishing the byte or a framing error
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_rx_if.master  bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    logic                      rx_s;
    logic                      rx_dly_q;
    uart_rx_state_t            state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [2:0]                bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] data_out_q;
    logic                      valid_q;
    logic                      frame_err_q;
    logic                      busy_q;
`ifdef UART_RX_PARITY_EN
    logic                      par_bad_q;
    logic                      parity_err_q;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.rx),
        .q_o   (rx_s)
    );

    // Delayed copy of the synchronized line for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_dly_q <= UART_IDLE_LEVEL;
        end else begin
            rx_dly_q <= rx_s;
        end
    end

    // Frame FSM with baud counter, bit index, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    // A held-low line has rx_dly_q low too, so a break cannot retrigger.
                    if (rx_dly_q && !rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        par_bad_q <= even_parity_bad(shift_q, rx_s);
                        state_q   <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif

                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (rx_s) begin
                            data_out_q <= shift_q;
                            valid_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= par_bad_q;
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx with CLKS_PER_BIT = 16.
module tb_uart_rx;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   vtimes[$];
    exp_t mon_e;

    uart_rx_if bus_if ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && (bus_if.valid || bus_if.frame_err || bus_if.parity_err)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: valid=%0b data_out=%02h parity_err=%0b frame_err=%0b, expected no output",
                         bus_if.valid, bus_if.data_out, bus_if.parity_err, bus_if.frame_err);
            end else begin
                mon_e = sb.pop_front();
                check("valid", bus_if.valid, mon_e.valid);
                check("data_out", bus_if.data_out, mon_e.data);
                check("parity_err", bus_if.parity_err, mon_e.perr);
                check("frame_err", bus_if.frame_err, mon_e.ferr);
                check("busy_at_pulse", bus_if.busy, 1'b0);
                if (bus_if.valid) vtimes.push_back(cyc);
            end
        end
    end

    // Each call starts on a negedge and returns on the negedge one bit later.
    task automatic send_bit(input logic v);
        bus_if.rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par) begin end
`endif
        send_bit(stop_b);
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic perr);
        exp_t e;
        e.valid = 1'b1; e.data = d; e.perr = perr; e.ferr = 1'b0;
        sb.push_back(e);
    endtask

    task automatic expect_ferr(input logic [7:0] held);
        exp_t e;
        e.valid = 1'b0; e.data = held; e.perr = 1'b0; e.ferr = 1'b1;
        sb.push_back(e);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((sb.size() != 0 || bus_if.busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 32'(n < max), 32'd1);
    endtask

    initial begin
        logic seen_hi;
        int   nv;
        rst_n     = 1'b0;
        bus_if.rx = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_data_out", bus_if.data_out, 8'h00);
        check("reset_valid", bus_if.valid, 1'b0);
        check("reset_parity_err", bus_if.parity_err, 1'b0);
        check("reset_frame_err", bus_if.frame_err, 1'b0);
        check("reset_busy", bus_if.busy, 1'b0);
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);

        // Good byte A5, even parity 0
        expect_byte(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1);
        send_bit(1'b1);
        drain(400);
        check("a5_busy_after", bus_if.busy, 1'b0);
        check("a5_data_held", bus_if.data_out, 8'hA5);

        // False start: 4-cycle glitch
        seen_hi = 1'b0;
        bus_if.rx = 1'b0;
        repeat (4) begin @(negedge clk); if (bus_if.busy) seen_hi = 1'b1; end
        bus_if.rx = 1'b1;
        repeat (40) begin @(negedge clk); if (bus_if.busy) seen_hi = 1'b1; end
        check("glitch_busy_seen", seen_hi, 1'b1);
        check("glitch_busy_low", bus_if.busy, 1'b0);
        check("glitch_data_kept", bus_if.data_out, 8'hA5);

        // Framing error on 3C, then 32-cycle break
        expect_ferr(8'hA5);
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (32) @(negedge clk);
        bus_if.rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        drain(400);
        check("ferr_data_kept", bus_if.data_out, 8'hA5);
        check("break_busy_low", bus_if.busy, 1'b0);

`ifdef UART_RX_PARITY_EN
        // Byte 01 with wrong parity 0
        expect_byte(8'h01, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1);
        send_bit(1'b1);
        drain(400);
        check("par_data_out", bus_if.data_out, 8'h01);
`endif

        // Reset in the middle of bit 4 of FF
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data_out", bus_if.data_out, 8'h00);
        check("midrst_valid", bus_if.valid, 1'b0);
        check("midrst_frame_err", bus_if.frame_err, 1'b0);
        check("midrst_parity_err", bus_if.parity_err, 1'b0);
        check("midrst_busy", bus_if.busy, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        expect_byte(8'h5A, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1);
        send_bit(1'b1);
        drain(400);
        check("post_rst_data", bus_if.data_out, 8'h5A);

        // Back-to-back 00 then FF with no idle gap
        nv = vtimes.size();
        expect_byte(8'h00, 1'b0);
        expect_byte(8'hFF, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_bit(1'b1);
        drain(400);
        check("b2b_pulse_count", vtimes.size() - nv, 2);
        if (vtimes.size() - nv == 2)
            check("b2b_spacing", vtimes[nv + 1] - vtimes[nv], FRAME_BITS * CPB);
        check("b2b_last_data", bus_if.data_out, 8'hFF);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
